uart_framed: RTL and testbench
==============================

Name: uart_framed

Overview:
Parametrised UART with configurable frame format, replacing the fixed 8N1 UART in the serial host-link path.
- Supports 5-8 data bits, none/odd/even parity, and 1 or 2 stop bits.
- Has internal TX/RX FIFOs, a false-start filter and sticky error flags.
- Raises a packet-end pulse after a configurable line-idle gap.
- Sits between the board UART pins and the command/packet parser.

Parameters:
CLOCK_FREQUENCY, 27000000, system clock in Hz
BAUD_RATE, 115200, line rate; BAUD_DIVISOR = CLOCK_FREQUENCY/BAUD_RATE (truncating integer division)
DATA_BITS, 8, data bits per frame, legal range 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 32, entries per FIFO, power of two, minimum 2
IDLE_BYTES, 1, idle gap in frame-times that marks packet end

Ports:
clock  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-low reset
uart_tx_pin  out  1  serial TX line, idles high
uart_rx_pin  in  1  serial RX line, asynchronous
tx_fifo_data_in  in  DATA_BITS  byte to transmit
tx_fifo_write_en  in  1  push tx_fifo_data_in into TX FIFO
tx_fifo_full  out  1  TX FIFO full
rx_fifo_data_out  out  DATA_BITS  head of RX FIFO (show-ahead)
rx_fifo_read_en  in  1  pop RX FIFO head
rx_fifo_empty  out  1  RX FIFO empty
rx_parity_error  out  1  sticky: frame discarded for bad parity
rx_frame_error  out  1  sticky: frame discarded for low stop bit
rx_overrun  out  1  sticky: good frame discarded, RX FIFO full
error_clear  in  1  clears all three sticky flags
UartPacketReceived  out  1  one-cycle pulse at end of idle gap

Behaviour:
- Reset (reset==0 at an edge):
  - Both FSMs go to IDLE and both FIFOs are emptied.
  - Outputs next cycle: uart_tx_pin=1, tx_fifo_full=0, rx_fifo_empty=1, all error flags 0, UartPacketReceived=0, rx_fifo_data_out=0.
  - Reset mid-frame aborts the frame immediately. The line stays high, so the partial frame is seen remotely as a truncated frame.
- FIFOs:
  - Write while full is dropped, even if a read occurs in the same cycle.
  - Read while empty is ignored.
  - Simultaneous read+write when neither full nor empty: both occur, and the occupancy count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - Each bit is held for exactly BAUD_DIVISOR cycles. STOP lasts STOP_BITS*BAUD_DIVISOR cycles.
  - Data is sent LSB first. Odd parity makes the total count of ones odd; even parity makes it even.
  - In IDLE with TX FIFO non-empty: pop the head and latch it. uart_tx_pin falls 2 cycles after the write edge into an empty FIFO.
  - Back-to-back frames: the next START follows STOP with zero idle cycles.
- RX synchroniser: two flops, both reset to 1. All RX logic uses the second flop.
- RX FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - In IDLE, a low synchronised line enters START. The start bit is re-checked BAUD_DIVISOR/2 cycles later; if the line is high, the FSM returns to IDLE and nothing is recorded.
  - Subsequent samples are taken every BAUD_DIVISOR cycles, at mid-bit.
  - Only the first stop bit is sampled. The FSM returns to IDLE right after that sample, which permits back-to-back frames.
- Frame disposition at the stop sample, in priority order:
  1. Stop bit low: set rx_frame_error, discard the frame.
  2. Parity mismatch: set rx_parity_error, discard the frame.
  3. RX FIFO full: set rx_overrun, discard the frame.
  4. Otherwise: write to the RX FIFO; rx_fifo_empty deasserts the cycle after the write.
- Sticky flags: error_clear clears them. If a set and a clear happen in the same cycle, set wins.
- Idle detection:
  - Gap length = BAUD_DIVISOR*(1+DATA_BITS+(PARITY!=0)+STOP_BITS)*IDLE_BYTES cycles.
  - The counter arms on any completed frame, valid or discarded.
  - It counts cycles while the RX FSM is in IDLE.
  - When the count reaches the gap length, UartPacketReceived pulses for one cycle and the counter disarms.
  - Entering START cancels and disarms the counter.
  - Counter width is $clog2(gap length + 1).

Optional Feature:
UART_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit), placed after error_clear.
  - When loopback=1, the RX synchroniser input is the internal TX serial bit instead of uart_rx_pin, and uart_tx_pin is forced to 1.
  - Changing loopback mid-frame is allowed and can cause a frame error.
- Undefined: the port is absent and RX always uses uart_rx_pin.

Decomposition:
- Package uart_pkg holds:
  - Parity encoding constants: PARITY_NONE, PARITY_ODD, PARITY_EVEN.
  - FSM state typedefs for TX and RX, states IDLE/START/DATA/PARITY/STOP.
  - A function frame_bits(DATA_BITS, PARITY, STOP_BITS).
- One sub-module, uart_sync_fifo (parameters WIDTH, DEPTH), instantiated twice: once for TX, once for RX.

Test Plan:
Bench defaults: CLOCK_FREQUENCY=27000000, BAUD_RATE=115200, BAUD_DIVISOR=234.
1. 8N1, write 0xA5 -> uart_tx_pin low 234 cycles, then bits 1,0,1,0,0,1,0,1 at 234 cycles each, then high. Frame = 2340 cycles; next frame starts with no gap if the FIFO is non-empty.
2. 8E1, drive 0x3C with parity bit 0 -> rx_fifo_empty=0 and rx_fifo_data_out=0x3C. UartPacketReceived pulses exactly once, 2574 idle cycles after the stop sample.
3. 8O1, drive 0x3C with parity bit 0 -> RX FIFO stays empty and rx_parity_error=1. Pulse error_clear -> flag reads 0 the next cycle.
4. Drive 0x55 with the stop bit low -> rx_frame_error=1, FIFO empty. A 50-cycle low glitch -> no frame, no flags, no pulse.
5. Send 33 valid bytes 0x00..0x20 with no reads -> 32 entries stored, rx_overrun=1. Reads return 0x00..0x1F in order, then rx_fifo_empty=1.
6. Assert reset mid-TX during the data bits -> uart_tx_pin=1 and tx_fifo_full=0 next cycle. No further TX activity until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state types and frame-length helper for uart_framed
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Bit-times per frame: start + data + optional parity + stop bits
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous show-ahead FIFO, power-of-two depth
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_en,
    output logic             o_full,
    output logic [WIDTH-1:0] o_rd_data,
    input  logic             i_rd_en,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    // A write into a full FIFO is dropped even when a read happens in the same cycle
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array, not reset; emptiness is tracked by the count alone
    always_ff @(posedge i_clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count holds on simultaneous read and write
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_framed.sv
// rtl/uart_framed.sv - configurable-frame UART with FIFOs, sticky errors and idle-gap packet pulse (option: UART_LOOPBACK_EN)
module uart_framed import uart_pkg::*; #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 32,
    parameter int IDLE_BYTES      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 uart_tx_pin,
    input  logic                 uart_rx_pin,
    input  logic [DATA_BITS-1:0] tx_fifo_data_in,
    input  logic                 tx_fifo_write_en,
    output logic                 tx_fifo_full,
    output logic [DATA_BITS-1:0] rx_fifo_data_out,
    input  logic                 rx_fifo_read_en,
    output logic                 rx_fifo_empty,
    output logic                 rx_parity_error,
    output logic                 rx_frame_error,
    output logic                 rx_overrun,
    input  logic                 error_clear,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    output logic                 UartPacketReceived
);

    localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = BAUD_DIVISOR / 2;
    localparam int STOP_LEN     = STOP_BITS * BAUD_DIVISOR;
    localparam int GAP_LEN      = BAUD_DIVISOR * frame_bits(DATA_BITS, PARITY, STOP_BITS) * IDLE_BYTES;
    localparam int CNT_W        = $clog2(STOP_LEN + 1);
    localparam int IDLE_W       = $clog2(GAP_LEN + 1);
    localparam int BIT_W        = $clog2(DATA_BITS);
    localparam bit HAS_PARITY   = (PARITY != PARITY_NONE);
    localparam bit ODD_PARITY   = (PARITY == PARITY_ODD);

    tx_state_t            r_tx_state;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic [BIT_W-1:0]     r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_pin;
    logic                 w_tx_bit;
    logic                 w_tx_pop;
    logic                 w_tx_bit_end;
    logic                 w_tx_stop_end;
    logic                 w_txf_empty;
    logic [DATA_BITS-1:0] w_txf_rd_data;

    rx_state_t            r_rx_state;
    logic [CNT_W-1:0]     r_rx_cnt;
    logic [BIT_W-1:0]     r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par;
    logic                 r_rx_s1;
    logic                 r_rx_s2;
    logic                 w_rx_line;
    logic                 w_rx_bit_end;
    logic                 w_rx_stop_sample;
    logic                 w_rx_par_bad;
    logic                 w_rx_frame_bad;
    logic                 w_rx_par_err;
    logic                 w_rx_ovr;
    logic                 w_rx_push;
    logic                 w_rxf_full;

    logic                 r_parity_error;
    logic                 r_frame_error;
    logic                 r_overrun;
    logic                 r_idle_armed;
    logic [IDLE_W-1:0]    r_idle_cnt;
    logic                 r_pkt;

`ifdef UART_LOOPBACK_EN
    assign w_rx_line   = loopback ? r_tx_pin : uart_rx_pin;
    assign uart_tx_pin = loopback ? 1'b1 : r_tx_pin;
`else
    assign w_rx_line   = uart_rx_pin;
    assign uart_tx_pin = r_tx_pin;
`endif

    assign rx_parity_error    = r_parity_error;
    assign rx_frame_error     = r_frame_error;
    assign rx_overrun         = r_overrun;
    assign UartPacketReceived = r_pkt;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clock   (clock),
        .i_resetn  (reset),
        .i_wr_data (tx_fifo_data_in),
        .i_wr_en   (tx_fifo_write_en),
        .o_full    (tx_fifo_full),
        .o_rd_data (w_txf_rd_data),
        .i_rd_en   (w_tx_pop),
        .o_empty   (w_txf_empty)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clock   (clock),
        .i_resetn  (reset),
        .i_wr_data (r_rx_shift),
        .i_wr_en   (w_rx_push),
        .o_full    (w_rxf_full),
        .o_rd_data (rx_fifo_data_out),
        .i_rd_en   (rx_fifo_read_en),
        .o_empty   (rx_fifo_empty)
    );

    // TX: a new frame is popped from IDLE or on the last STOP cycle, so frames chain with no idle gap
    assign w_tx_bit_end  = (r_tx_cnt == CNT_W'(BAUD_DIVISOR - 1));
    assign w_tx_stop_end = (r_tx_state == TX_STOP) && (r_tx_cnt == CNT_W'(STOP_LEN - 1));
    assign w_tx_pop      = !w_txf_empty && ((r_tx_state == TX_IDLE) || w_tx_stop_end);

    // Line level implied by the current TX state; registered into the pin one cycle later
    always_comb begin
        w_tx_bit = 1'b1;
        case (r_tx_state)
            TX_START:  w_tx_bit = 1'b0;
            TX_DATA:   w_tx_bit = r_tx_shift[0];
            TX_PARITY: w_tx_bit = r_tx_par;
            default:   w_tx_bit = 1'b1;
        endcase
    end

    // TX FSM: holds each bit BAUD_DIVISOR cycles, LSB first, parity precomputed at pop time
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_pin   <= 1'b1;
        end else begin
            r_tx_pin <= w_tx_bit;
            if (w_tx_pop) begin
                r_tx_state <= TX_START;
                r_tx_cnt   <= '0;
                r_tx_shift <= w_txf_rd_data;
                r_tx_par   <= (^w_txf_rd_data) ^ ODD_PARITY;
            end else begin
                case (r_tx_state)
                    TX_START: begin
                        if (w_tx_bit_end) begin
                            r_tx_cnt   <= '0;
                            r_tx_bit   <= '0;
                            r_tx_state <= TX_DATA;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
                    TX_DATA: begin
                        if (w_tx_bit_end) begin
                            r_tx_cnt   <= '0;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            if (r_tx_bit == BIT_W'(DATA_BITS - 1)) begin
                                r_tx_state <= HAS_PARITY ? TX_PARITY : TX_STOP;
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
                    TX_PARITY: begin
                        if (w_tx_bit_end) begin
                            r_tx_cnt   <= '0;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
                    TX_STOP: begin
                        if (w_tx_stop_end) begin
                            r_tx_cnt   <= '0;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_IDLE;
                    end
                endcase
            end
        end
    end

    // Two-flop synchroniser for the asynchronous RX line, idling high
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= w_rx_line;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // Frame disposition at the stop sample: stop error beats parity error beats overrun
    assign w_rx_bit_end     = (r_rx_cnt == CNT_W'(BAUD_DIVISOR - 1));
    assign w_rx_stop_sample = (r_rx_state == RX_STOP) && w_rx_bit_end;
    assign w_rx_par_bad     = HAS_PARITY && (r_rx_par != ((^r_rx_shift) ^ ODD_PARITY));
    assign w_rx_frame_bad   = w_rx_stop_sample && !r_rx_s2;
    assign w_rx_par_err     = w_rx_stop_sample && r_rx_s2 && w_rx_par_bad;
    assign w_rx_ovr         = w_rx_stop_sample && r_rx_s2 && !w_rx_par_bad && w_rxf_full;
    assign w_rx_push        = w_rx_stop_sample && r_rx_s2 && !w_rx_par_bad && !w_rxf_full;

    // RX FSM: half-bit start re-check, then mid-bit samples; only the first stop bit is sampled
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (!r_rx_s2) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == CNT_W'(HALF_BIT - 1)) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == BIT_W'(DATA_BITS - 1)) begin
                            r_rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_par   <= r_rx_s2;
                        r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps its flag set
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (w_rx_frame_bad) begin
                r_frame_error <= 1'b1;
            end else if (error_clear) begin
                r_frame_error <= 1'b0;
            end
            if (w_rx_par_err) begin
                r_parity_error <= 1'b1;
            end else if (error_clear) begin
                r_parity_error <= 1'b0;
            end
            if (w_rx_ovr) begin
                r_overrun <= 1'b1;
            end else if (error_clear) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Idle-gap timer: armed by any completed frame, cancelled by a new start, pulses once at GAP_LEN
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_idle_armed <= 1'b0;
            r_idle_cnt   <= '0;
            r_pkt        <= 1'b0;
        end else begin
            r_pkt <= 1'b0;
            if (w_rx_stop_sample) begin
                r_idle_armed <= 1'b1;
                r_idle_cnt   <= '0;
            end else if ((r_rx_state == RX_IDLE) && !r_rx_s2) begin
                r_idle_armed <= 1'b0;
                r_idle_cnt   <= '0;
            end else if (r_idle_armed && (r_rx_state == RX_IDLE)) begin
                if (r_idle_cnt == IDLE_W'(GAP_LEN - 1)) begin
                    r_pkt        <= 1'b1;
                    r_idle_armed <= 1'b0;
                    r_idle_cnt   <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_framed.sv
// tb/tb_uart_framed.sv - randomized self-checking bench for uart_framed (8N1 TX at 234, 8E1 RX at 16)
module tb_uart_framed;

    localparam int DIV_A   = 234;
    localparam int DIV_B   = 16;
    localparam int GAP_B   = DIV_B * 11;
    localparam int FRAME_A = DIV_A * 10;
    localparam int TRACE_N = 2 + 2 * FRAME_A + 30;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic       tx_a, rx_a = 1'b1, txwr_a = 1'b0, txfull_a, rxrd_a = 1'b0, rxempty_a;
    logic       perr_a, ferr_a, ovr_a, clr_a = 1'b0, pkt_a;
    logic [7:0] txd_a = 8'h00, rxd_a;
    logic       tx_b, rx_b = 1'b1, txwr_b = 1'b0, txfull_b, rxrd_b = 1'b0, rxempty_b;
    logic       perr_b, ferr_b, ovr_b, clr_b = 1'b0, pkt_b;
    logic [7:0] txd_b = 8'h00, rxd_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pkt_a_n = 0, pkt_b_n = 0;
    int t_fill_b = 0, t_pkt_b = 0;
    logic prev_empty_b = 1'b1;
    logic trace [TRACE_N];

    uart_framed u_dut_a (
        .clock(clock), .reset(reset), .uart_tx_pin(tx_a), .uart_rx_pin(rx_a),
        .tx_fifo_data_in(txd_a), .tx_fifo_write_en(txwr_a), .tx_fifo_full(txfull_a),
        .rx_fifo_data_out(rxd_a), .rx_fifo_read_en(rxrd_a), .rx_fifo_empty(rxempty_a),
        .rx_parity_error(perr_a), .rx_frame_error(ferr_a), .rx_overrun(ovr_a),
        .error_clear(clr_a), .UartPacketReceived(pkt_a)
    );

    uart_framed #(.CLOCK_FREQUENCY(27000000), .BAUD_RATE(1687500), .PARITY(2)) u_dut_b (
        .clock(clock), .reset(reset), .uart_tx_pin(tx_b), .uart_rx_pin(rx_b),
        .tx_fifo_data_in(txd_b), .tx_fifo_write_en(txwr_b), .tx_fifo_full(txfull_b),
        .rx_fifo_data_out(rxd_b), .rx_fifo_read_en(rxrd_b), .rx_fifo_empty(rxempty_b),
        .rx_parity_error(perr_b), .rx_frame_error(ferr_b), .rx_overrun(ovr_b),
        .error_clear(clr_b), .UartPacketReceived(pkt_b)
    );

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (pkt_a === 1'b1) pkt_a_n++;
        if (pkt_b === 1'b1) begin
            pkt_b_n++;
            t_pkt_b = cyc;
        end
        if (prev_empty_b === 1'b1 && rxempty_b === 1'b0) t_fill_b = cyc;
        prev_empty_b = rxempty_b;
    end

    // Expected 8N1 line level t cycles after the write edge: 2 idle cycles, then frames b0, b1
    function automatic logic exp_line(input int t, input logic [7:0] b0, input logic [7:0] b1);
        int u, f, pos;
        logic [7:0] b;
        if (t < 2) return 1'b1;
        u = t - 2;
        f = u / FRAME_A;
        if (f > 1) return 1'b1;
        pos = (u % FRAME_A) / DIV_A;
        b = (f == 0) ? b0 : b1;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    // Drive one 8E1 frame into dut_b; par_ok/stop_ok select a correct or corrupted bit
    task automatic send_b(input logic [7:0] d, input bit par_ok, input bit stop_ok);
        logic [10:0] bits;
        bits = {stop_ok ? 1'b1 : 1'b0, par_ok ? ^d : ~^d, d, 1'b0};
        @(posedge clock);
        #1;
        for (int i = 0; i < 11; i++) begin
            rx_b = bits[i];
            repeat (DIV_B) @(posedge clock);
            #1;
        end
        rx_b = 1'b1;
    endtask

    task automatic clear_b();
        @(negedge clock); clr_b = 1'b1;
        @(negedge clock); clr_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx_pin: got %b want 1", tx_a); end
        checks++; if (txfull_a !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b want 0", txfull_a); end
        checks++; if (rxempty_b !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b want 1", rxempty_b); end
        checks++; if (rxd_b !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rxd_b); end
        checks++; if ({perr_b, ferr_b, ovr_b, pkt_b} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {perr_b, ferr_b, ovr_b, pkt_b}); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_tx_frame();
        logic [7:0] b1;
        int first_low, bad;
        logic want;
        b1 = 8'($urandom);
        @(negedge clock); txd_a = 8'hA5; txwr_a = 1'b1;
        @(posedge clock);
        for (int t = 0; t < TRACE_N; t++) begin
            @(negedge clock);
            trace[t] = tx_a;
            if (t == 0) txd_a = b1;
            if (t == 1) txwr_a = 1'b0;
        end
        first_low = -1;
        for (int t = TRACE_N - 1; t >= 0; t--) if (trace[t] == 1'b0) first_low = t;
        checks++; if (first_low != 2) begin errors++; $display("FAIL tx_fall: got %0d want 2", first_low); end
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 10; p++) begin
                bad = 0;
                want = exp_line(2 + f * FRAME_A + p * DIV_A, 8'hA5, b1);
                for (int k = 0; k < DIV_A; k++) begin
                    if (trace[2 + f * FRAME_A + p * DIV_A + k] !== want) bad++;
                end
                checks++;
                if (bad != 0) begin errors++; $display("FAIL tx_bit f%0d p%0d: %0d samples off, want level %b", f, p, bad, want); end
            end
        end
        bad = 0;
        for (int t = 2 + 2 * FRAME_A; t < TRACE_N; t++) if (trace[t] !== 1'b1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL tx_tail: got %0d low samples want 0", bad); end
    endtask

    task automatic test_glitch();
        int base;
        base = pkt_a_n;
        @(negedge clock); rx_a = 1'b0;
        repeat (50) @(negedge clock);
        rx_a = 1'b1;
        repeat (3000) @(negedge clock);
        checks++; if (rxempty_a !== 1'b1) begin errors++; $display("FAIL glitch_empty: got %b want 1", rxempty_a); end
        checks++; if ({perr_a, ferr_a, ovr_a} !== 3'b000) begin errors++; $display("FAIL glitch_flags: got %b want 000", {perr_a, ferr_a, ovr_a}); end
        checks++; if (pkt_a_n != base) begin errors++; $display("FAIL glitch_pkt: got %0d pulses want 0", pkt_a_n - base); end
    endtask

    task automatic test_rx_good();
        int base;
        logic [7:0] d;
        d = 8'h3C;
        base = pkt_b_n;
        send_b(d, 1'b1, 1'b1);
        for (int k = 0; k < GAP_B + 100 && pkt_b_n == base; k++) @(negedge clock);
        checks++; if (rxempty_b !== 1'b0) begin errors++; $display("FAIL good_empty: got %b want 0", rxempty_b); end
        checks++; if (rxd_b !== d) begin errors++; $display("FAIL good_data: got %h want %h", rxd_b, d); end
        checks++; if (t_pkt_b - t_fill_b != GAP_B) begin errors++; $display("FAIL pkt_gap: got %0d want %0d", t_pkt_b - t_fill_b, GAP_B); end
        repeat (2 * GAP_B) @(negedge clock);
        checks++; if (pkt_b_n - base != 1) begin errors++; $display("FAIL pkt_once: got %0d want 1", pkt_b_n - base); end
        rxrd_b = 1'b1;
        @(negedge clock); rxrd_b = 1'b0;
        checks++; if (rxempty_b !== 1'b1) begin errors++; $display("FAIL good_pop: got %b want 1", rxempty_b); end
    endtask

    task automatic test_rx_errors();
        send_b(8'h3C, 1'b0, 1'b1);
        repeat (DIV_B) @(negedge clock);
        checks++; if (perr_b !== 1'b1) begin errors++; $display("FAIL par_flag: got %b want 1", perr_b); end
        checks++; if (rxempty_b !== 1'b1) begin errors++; $display("FAIL par_empty: got %b want 1", rxempty_b); end
        clr_b = 1'b1;
        @(negedge clock); clr_b = 1'b0;
        checks++; if (perr_b !== 1'b0) begin errors++; $display("FAIL par_clear: got %b want 0", perr_b); end
        send_b(8'h55, 1'b1, 1'b0);
        repeat (2 * DIV_B) @(negedge clock);
        checks++; if ({ferr_b, perr_b} !== 2'b10) begin errors++; $display("FAIL frame_flag: got %b want 10", {ferr_b, perr_b}); end
        checks++; if (rxempty_b !== 1'b1) begin errors++; $display("FAIL frame_empty: got %b want 1", rxempty_b); end
        clear_b();
    endtask

    task automatic test_overrun();
        for (int i = 0; i <= 32; i++) send_b(8'(i), 1'b1, 1'b1);
        repeat (DIV_B) @(negedge clock);
        checks++; if ({ovr_b, perr_b, ferr_b} !== 3'b100) begin errors++; $display("FAIL ovr_flags: got %b want 100", {ovr_b, perr_b, ferr_b}); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (rxd_b !== 8'(i)) begin errors++; $display("FAIL ovr_read%0d: got %h want %h", i, rxd_b, 8'(i)); end
            rxrd_b = 1'b1;
            @(negedge clock); rxrd_b = 1'b0;
        end
        checks++; if (rxempty_b !== 1'b1) begin errors++; $display("FAIL ovr_drain: got %b want 1", rxempty_b); end
        clear_b();
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] d, want;
        logic exp_p, exp_f;
        int kind;
        exp_p = 1'b0;
        exp_f = 1'b0;
        for (int n = 0; n < 16; n++) begin
            d = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                send_b(d, 1'b1, 1'b1);
                q.push_back(d);
            end else if (kind < 8) begin
                send_b(d, 1'b0, 1'b1);
                exp_p = 1'b1;
            end else begin
                send_b(d, 1'b1, 1'b0);
                exp_f = 1'b1;
            end
            repeat (2 * DIV_B) @(negedge clock);
        end
        checks++; if ({perr_b, ferr_b, ovr_b} !== {exp_p, exp_f, 1'b0}) begin errors++; $display("FAIL rnd_flags: got %b want %b", {perr_b, ferr_b, ovr_b}, {exp_p, exp_f, 1'b0}); end
        while (q.size() > 0) begin
            want = q.pop_front();
            checks++; if (rxd_b !== want) begin errors++; $display("FAIL rnd_data: got %h want %h", rxd_b, want); end
            rxrd_b = 1'b1;
            @(negedge clock); rxrd_b = 1'b0;
        end
        checks++; if (rxempty_b !== 1'b1) begin errors++; $display("FAIL rnd_drain: got %b want 1", rxempty_b); end
        clear_b();
    endtask

    task automatic test_tx_reset();
        int lows;
        @(negedge clock); txwr_a = 1'b1;
        for (int i = 0; i < 34; i++) begin
            txd_a = 8'($urandom);
            @(negedge clock);
        end
        txwr_a = 1'b0;
        checks++; if (txfull_a !== 1'b1) begin errors++; $display("FAIL tx_full: got %b want 1", txfull_a); end
        repeat (400) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rst_tx_pin: got %b want 1", tx_a); end
        checks++; if (txfull_a !== 1'b0) begin errors++; $display("FAIL rst_tx_full: got %b want 0", txfull_a); end
        lows = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (tx_a !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL rst_tx_quiet: got %0d low cycles want 0", lows); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_glitch();
        test_rx_good();
        test_rx_errors();
        test_overrun();
        test_random();
        test_tx_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
